// File: rtl/snitch_vfpr_banked_if.sv
// Request/response and bank-macro bundle for the banked vector FP register file.
//
// master : the vector datapath side (drives requests) together with the bank
//          macros (drive read data); it observes grants, responses and bank
//          controls.
// slave  : the register file front-end itself.
//
// Signals (widths follow the parameters):
//   req_valid_i/req_ready_o   per-port TCDM-style request handshake
//   req_addr_i/req_write_i    word address and direction per port
//   req_wdata_i/req_strb_i    write data and byte strobes per port
//   rsp_valid_o/rsp_data_o    fixed-latency response per port
//   mem_*                     per-bank single-cycle SRAM interface
interface snitch_vfpr_banked_if #(
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned NumBanks      = 4,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned AddrWidth     = 10,
   parameter int unsigned BankAddrWidth = AddrWidth - $clog2(NumBanks)
) ();

   logic [NumPorts-1:0]                 req_valid_i;
   logic [NumPorts-1:0]                 req_ready_o;
   logic [NumPorts*AddrWidth-1:0]       req_addr_i;
   logic [NumPorts-1:0]                 req_write_i;
   logic [NumPorts*DataWidth-1:0]       req_wdata_i;
   logic [NumPorts*DataWidth/8-1:0]     req_strb_i;
   logic [NumPorts-1:0]                 rsp_valid_o;
   logic [NumPorts*DataWidth-1:0]       rsp_data_o;
   logic [NumBanks-1:0]                 mem_req_o;
   logic [NumBanks-1:0]                 mem_we_o;
   logic [NumBanks*BankAddrWidth-1:0]   mem_addr_o;
   logic [NumBanks*DataWidth-1:0]       mem_wdata_o;
   logic [NumBanks*DataWidth/8-1:0]     mem_be_o;
   logic [NumBanks*DataWidth-1:0]       mem_rdata_i;

   modport master (
      output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_data_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

endinterface

// File: rtl/snitch_vfpr_banked.sv
// Banked vector FP register file front-end.
//
// Connects NumPorts request ports to NumBanks word-interleaved single-cycle
// SRAM banks. Each bank arbitrates its candidates round-robin within the
// cycle; a granted port gets its response exactly one cycle later. Stalled
// requests are accumulated in a saturating conflict counter.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   clear_cnt_i     synchronous clear of the conflict counter (beats increment)
//   conflict_cnt_o  saturating count of stalled request-cycles (registered)
//   bus             request/response and bank-macro bundle (slave side)
module snitch_vfpr_banked #(
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned NumBanks      = 4,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned AddrWidth     = 10,
   parameter int unsigned BankAddrWidth = AddrWidth - $clog2(NumBanks),
   parameter int unsigned CntWidth      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_cnt_i,
   output logic [CntWidth-1:0]  conflict_cnt_o,
   snitch_vfpr_banked_if.slave  bus
);

   localparam int unsigned BankSelW = $clog2(NumBanks);
   localparam int unsigned PortIdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned StrbW    = DataWidth / 8;
   localparam int unsigned StallW   = $clog2(NumPorts + 1);

   logic [BankSelW-1:0]             port_bank_s [NumPorts];
   logic [PortIdxW-1:0]             rr_ptr_r    [NumBanks];
   logic [PortIdxW-1:0]             winner_s    [NumBanks];
   logic [PortIdxW-1:0]             nxt_ptr_s   [NumBanks];
   logic [NumPorts-1:0]             grant_mat_s [NumBanks];
   logic [NumBanks-1:0]             gnt_s;
   logic [NumPorts-1:0]             ready_s;

   logic [NumBanks-1:0]             mem_we_s;
   logic [NumBanks*BankAddrWidth-1:0] mem_addr_s;
   logic [NumBanks*DataWidth-1:0]   mem_wdata_s;
   logic [NumBanks*StrbW-1:0]       mem_be_s;

   logic [NumPorts-1:0]             rsp_valid_r;
   logic [NumPorts-1:0]             was_read_r;
   logic [BankSelW-1:0]             bank_sel_r  [NumPorts];
   logic [NumPorts*DataWidth-1:0]   rsp_data_s;

   logic [StallW-1:0]               stall_s;
   logic [CntWidth:0]               cnt_sum_s;
   logic [CntWidth-1:0]             cnt_r;

   // Bank selection: low address bits interleave consecutive words across banks.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         port_bank_s[p] = bus.req_addr_i[p*AddrWidth +: BankSelW];
      end
   end

   // Per-bank round-robin: scan ports in priority order starting at rr_ptr.
   // The outer loop walks priority, the inner loop matches the port index so
   // every select stays constant-indexed.
   always_comb begin
      logic hit;
      hit     = 1'b0;
      gnt_s   = '0;
      ready_s = '0;
      for (int b = 0; b < NumBanks; b++) begin
         winner_s[b]    = '0;
         grant_mat_s[b] = '0;
         for (int k = 0; k < NumPorts; k++) begin
            for (int p = 0; p < NumPorts; p++) begin
               hit = !gnt_s[b] && bus.req_valid_i[p]
                     && (port_bank_s[p] == BankSelW'(b))
                     && (((int'(rr_ptr_r[b]) + k) % int'(NumPorts)) == p);
               gnt_s[b]          = gnt_s[b] | hit;
               ready_s[p]        = ready_s[p] | hit;
               grant_mat_s[b][p] = grant_mat_s[b][p] | hit;
               winner_s[b]       = hit ? PortIdxW'(p) : winner_s[b];
            end
         end
         nxt_ptr_s[b] = PortIdxW'((int'(winner_s[b]) + 1) % int'(NumPorts));
      end
   end

   // Bank drive: AND-OR mux of the winning port's payload (all zero when idle).
   always_comb begin
      mem_we_s    = '0;
      mem_addr_s  = '0;
      mem_wdata_s = '0;
      mem_be_s    = '0;
      for (int b = 0; b < NumBanks; b++) begin
         for (int p = 0; p < NumPorts; p++) begin
            mem_we_s[b] = mem_we_s[b] | (grant_mat_s[b][p] & bus.req_write_i[p]);
            mem_addr_s[b*BankAddrWidth +: BankAddrWidth] |= {BankAddrWidth{grant_mat_s[b][p]}}
               & bus.req_addr_i[p*AddrWidth + BankSelW +: BankAddrWidth];
            mem_wdata_s[b*DataWidth +: DataWidth] |= {DataWidth{grant_mat_s[b][p]}}
               & bus.req_wdata_i[p*DataWidth +: DataWidth];
            mem_be_s[b*StrbW +: StrbW] |= {StrbW{grant_mat_s[b][p]}}
               & bus.req_strb_i[p*StrbW +: StrbW];
         end
      end
   end

   // Response data: read data of the bank granted last cycle, zero for writes/idle.
   always_comb begin
      rsp_data_s = '0;
      for (int p = 0; p < NumPorts; p++) begin
         for (int b = 0; b < NumBanks; b++) begin
            rsp_data_s[p*DataWidth +: DataWidth] |=
               {DataWidth{rsp_valid_r[p] & was_read_r[p] & (bank_sel_r[p] == BankSelW'(b))}}
               & bus.mem_rdata_i[b*DataWidth +: DataWidth];
         end
      end
   end

   // Stall count for this cycle and the widened sum used for saturation.
   always_comb begin
      stall_s = '0;
      for (int p = 0; p < NumPorts; p++) begin
         stall_s = stall_s + StallW'(bus.req_valid_i[p] & ~ready_s[p]);
      end
      cnt_sum_s = {1'b0, cnt_r} + (CntWidth+1)'(stall_s);
   end

   // State: RR pointers, response pipeline and conflict counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) begin
            rr_ptr_r[b] <= '0;
         end
         for (int p = 0; p < NumPorts; p++) begin
            bank_sel_r[p] <= '0;
         end
         rsp_valid_r <= '0;
         was_read_r  <= '0;
         cnt_r       <= '0;
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            if (gnt_s[b]) begin
               rr_ptr_r[b] <= nxt_ptr_s[b];
            end
         end
         rsp_valid_r <= ready_s;
         for (int p = 0; p < NumPorts; p++) begin
            if (ready_s[p]) begin
               bank_sel_r[p] <= port_bank_s[p];
               was_read_r[p] <= ~bus.req_write_i[p];
            end
         end
         if (clear_cnt_i) begin
            cnt_r <= '0;
         end else if (cnt_sum_s[CntWidth]) begin
            cnt_r <= '1;
         end else begin
            cnt_r <= cnt_sum_s[CntWidth-1:0];
         end
      end
   end

   assign bus.req_ready_o = ready_s;
   assign bus.rsp_valid_o = rsp_valid_r;
   assign bus.rsp_data_o  = rsp_data_s;
   assign bus.mem_req_o   = gnt_s;
   assign bus.mem_we_o    = mem_we_s;
   assign bus.mem_addr_o  = mem_addr_s;
   assign bus.mem_wdata_o = mem_wdata_s;
   assign bus.mem_be_o    = mem_be_s;
   assign conflict_cnt_o  = cnt_r;

endmodule

// File: tb/tb_snitch_vfpr_banked.sv
// Directed bench for snitch_vfpr_banked: 2 ports, 4 banks, 64-bit words,
// 10-bit addresses, 4-bit conflict counter, with a behavioural SRAM per bank.
module tb_snitch_vfpr_banked;

   localparam int NP  = 2;
   localparam int NB  = 4;
   localparam int DW  = 64;
   localparam int AW  = 10;
   localparam int BAW = 8;
   localparam int CW  = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr   = 1'b0;
   logic [CW-1:0] cnt;

   int n_cmp = 0;
   int n_err = 0;

   snitch_vfpr_banked_if #(.NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW)) bus ();

   snitch_vfpr_banked #(
      .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW), .CntWidth(CW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_cnt_i    (clr),
      .conflict_cnt_o (cnt),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   // Bank SRAM model: preloaded while in reset, read data registered.
   logic [63:0] mem   [NB][256];
   logic [63:0] rdata [NB];
   assign bus.mem_rdata_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

   always @(posedge clk) begin
      int row;
      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 256; r++) mem[b][r] <= 64'd0;
            rdata[b] <= 64'd0;
         end
         mem[1][1] <= 64'h0000_0000_0000_DEAD;
         mem[0][1] <= 64'h0000_0000_0000_1004;
         mem[3][1] <= 64'h0000_0000_0000_1007;
         mem[2][0] <= 64'h0000_0000_0000_2002;
         mem[2][1] <= 64'h0000_0000_0000_2006;
         mem[2][2] <= 64'hAAAA_BBBB_CCCC_DDDD;
         mem[3][0] <= 64'h0000_0000_0000_3003;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (bus.mem_req_o[b]) begin
               row = int'(bus.mem_addr_o[b*BAW +: BAW]);
               if (bus.mem_we_o[b]) begin
                  for (int i = 0; i < 8; i++) begin
                     if (bus.mem_be_o[b*8+i]) mem[b][row][8*i +: 8] <= bus.mem_wdata_o[b*DW+8*i +: 8];
                  end
               end else begin
                  rdata[b] <= mem[b][row];
               end
            end
         end
      end
   end

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  write;
      logic [9:0]  a0;
      logic [9:0]  a1;
      logic [63:0] wd;
      logic [15:0] strb;
      logic        clr;
      logic [1:0]  e_ready;
      logic [3:0]  e_mreq;
      logic [3:0]  e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mbe;
      logic [1:0]  e_rv;
      logic [63:0] e_d0;
      logic [63:0] e_d1;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.req_valid_i = v.valid;
      bus.req_write_i = v.write;
      bus.req_addr_i  = {v.a1, v.a0};
      bus.req_wdata_i = {v.wd, v.wd};
      bus.req_strb_i  = v.strb;
      clr             = v.clr;
   endtask

   task automatic set_req(input logic [1:0] valid, input logic [9:0] a0, input logic [9:0] a1);
      bus.req_valid_i = valid;
      bus.req_write_i = 2'b00;
      bus.req_addr_i  = {a1, a0};
      bus.req_wdata_i = '0;
      bus.req_strb_i  = 16'h0000;
   endtask

   initial begin
      // valid write a0 a1 wdata strb clr | ready mreq mwe maddr mbe | rv d0 d1 cnt
      vecs[0]  = '{2'b00, 2'b00, 10'h000, 10'h000, 64'h0, 16'h0000, 1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2'b00, 64'h0, 64'h0, 4'd0};
      vecs[1]  = '{2'b01, 2'b00, 10'h005, 10'h000, 64'h0, 16'h0000, 1'b0, 2'b01, 4'b0010, 4'b0000, 32'h0000_0100, 32'h0000_0000, 2'b01, 64'hDEAD, 64'h0, 4'd0};
      vecs[2]  = '{2'b11, 2'b00, 10'h004, 10'h007, 64'h0, 16'h0000, 1'b0, 2'b11, 4'b1001, 4'b0000, 32'h0100_0001, 32'h0000_0000, 2'b11, 64'h1004, 64'h1007, 4'd0};
      vecs[3]  = '{2'b11, 2'b00, 10'h002, 10'h006, 64'h0, 16'h0000, 1'b0, 2'b01, 4'b0100, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2'b01, 64'h2002, 64'h0, 4'd1};
      vecs[4]  = '{2'b11, 2'b00, 10'h002, 10'h006, 64'h0, 16'h0000, 1'b0, 2'b10, 4'b0100, 4'b0000, 32'h0001_0000, 32'h0000_0000, 2'b10, 64'h0, 64'h2006, 4'd2};
      vecs[5]  = '{2'b11, 2'b00, 10'h002, 10'h006, 64'h0, 16'h0000, 1'b0, 2'b01, 4'b0100, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2'b01, 64'h2002, 64'h0, 4'd3};
      vecs[6]  = '{2'b11, 2'b00, 10'h002, 10'h006, 64'h0, 16'h0000, 1'b0, 2'b10, 4'b0100, 4'b0000, 32'h0001_0000, 32'h0000_0000, 2'b10, 64'h0, 64'h2006, 4'd4};
      vecs[7]  = '{2'b10, 2'b10, 10'h000, 10'h00A, 64'h1122_3344_5566_7788, 16'h0F00, 1'b0, 2'b10, 4'b0100, 4'b0100, 32'h0002_0000, 32'h000F_0000, 2'b10, 64'h0, 64'h0, 4'd4};
      vecs[8]  = '{2'b10, 2'b00, 10'h000, 10'h00A, 64'h0, 16'h0000, 1'b0, 2'b10, 4'b0100, 4'b0000, 32'h0002_0000, 32'h0000_0000, 2'b10, 64'h0, 64'hAAAA_BBBB_5566_7788, 4'd4};
      vecs[9]  = '{2'b01, 2'b01, 10'h003, 10'h000, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 2'b01, 4'b1000, 4'b1000, 32'h0000_0000, 32'h0000_0000, 2'b01, 64'h0, 64'h0, 4'd4};
      vecs[10] = '{2'b01, 2'b00, 10'h003, 10'h000, 64'h0, 16'h0000, 1'b0, 2'b01, 4'b1000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2'b01, 64'h3003, 64'h0, 4'd4};

      set_req(2'b00, 10'h000, 10'h000);
      clr = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      chk("reset rsp_data",  64'(bus.rsp_data_o),  64'h0);
      chk("reset cnt",       64'(cnt),             64'h0);
      chk("reset mem_req",   64'(bus.mem_req_o),   64'h0);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d ready", i),    64'(bus.req_ready_o), 64'(vecs[i].e_ready));
         chk($sformatf("v%0d mem_req", i),  64'(bus.mem_req_o),   64'(vecs[i].e_mreq));
         chk($sformatf("v%0d mem_we", i),   64'(bus.mem_we_o),    64'(vecs[i].e_mwe));
         chk($sformatf("v%0d mem_addr", i), 64'(bus.mem_addr_o),  64'(vecs[i].e_maddr));
         chk($sformatf("v%0d mem_be", i),   64'(bus.mem_be_o),    64'(vecs[i].e_mbe));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d rsp_valid", i), 64'(bus.rsp_valid_o), 64'(vecs[i].e_rv));
         chk($sformatf("v%0d rsp_data0", i), bus.rsp_data_o[63:0],   vecs[i].e_d0);
         chk($sformatf("v%0d rsp_data1", i), bus.rsp_data_o[127:64], vecs[i].e_d1);
         chk($sformatf("v%0d cnt", i),       64'(cnt),               64'(vecs[i].e_cnt));
      end

      // Sustained bank0 conflict: rr_ptr[0] is 1 here, so port1 leads
      set_req(2'b11, 10'h000, 10'h004);
      for (int i = 0; i < 20; i++) begin
         #1;
         chk($sformatf("sat%0d ready", i), 64'(bus.req_ready_o), (i % 2 == 0) ? 64'h2 : 64'h1);
         @(posedge clk);
         #1;
      end
      chk("sat cnt", 64'(cnt), 64'hF);

      // Clear beats the stall of the same cycle
      clr = 1'b1;
      @(posedge clk);
      #1;
      chk("clear cnt", 64'(cnt), 64'h0);
      clr = 1'b0;
      @(posedge clk);
      #1;
      chk("post-clear cnt", 64'(cnt), 64'h1);

      // Lone port0 grant on bank0 moves rr_ptr[0] to 1
      set_req(2'b01, 10'h000, 10'h000);
      @(posedge clk);
      #1;
      chk("lone cnt", 64'(cnt), 64'h1);

      // Reset with a read response in flight
      set_req(2'b01, 10'h005, 10'h000);
      @(posedge clk);
      #1;
      chk("inflight rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
      chk("inflight rsp_data0", bus.rsp_data_o[63:0], 64'hDEAD);
      rst_n = 1'b0;
      set_req(2'b00, 10'h000, 10'h000);
      #1;
      chk("mid-reset rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      chk("mid-reset rsp_data0", bus.rsp_data_o[63:0], 64'h0);
      chk("mid-reset cnt",       64'(cnt),             64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_req(2'b11, 10'h000, 10'h004);
      #1;
      chk("post-reset rr ready", 64'(bus.req_ready_o), 64'h1);
      @(posedge clk);
      #1;
      chk("post-reset rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
      chk("post-reset cnt",       64'(cnt),             64'h1);
      set_req(2'b00, 10'h000, 10'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/snitch_vfpr_banked.md
Name: snitch_vfpr_banked

Overview:
Parametrised vector FP register file front-end. It connects NumPorts TCDM-style request ports to NumBanks word-interleaved single-cycle SRAM banks. Each bank has its own round-robin arbitration, and responses return with a fixed latency. A saturating conflict counter is provided for performance analysis. It sits between the FPU/SSR vector datapath and the vfpr bank macros.

Parameters:
NumPorts, 2, number of independent request ports (>=1)
NumBanks, 4, number of banks; power of two, >=2
DataWidth, 64, word width in bits; multiple of 8
AddrWidth, 10, word address width per port
BankAddrWidth, AddrWidth-$clog2(NumBanks), derived; row address within a bank
CntWidth, 32, conflict counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NumPorts  request valid per port
req_ready_o  out  NumPorts  request granted this cycle
req_addr_i  in  NumPorts*AddrWidth  word address per port
req_write_i  in  NumPorts  1=write, 0=read
req_wdata_i  in  NumPorts*DataWidth  write data
req_strb_i  in  NumPorts*DataWidth/8  byte strobes
rsp_valid_o  out  NumPorts  response valid
rsp_data_o  out  NumPorts*DataWidth  read data (0 for writes)
mem_req_o  out  NumBanks  bank enable
mem_we_o  out  NumBanks  bank write enable
mem_addr_o  out  NumBanks*BankAddrWidth  bank row address
mem_wdata_o  out  NumBanks*DataWidth  bank write data
mem_be_o  out  NumBanks*DataWidth/8  bank byte enables
mem_rdata_i  in  NumBanks*DataWidth  bank read data, valid the cycle after mem_req_o
conflict_cnt_o  out  CntWidth  saturating count of stalled requests
clear_cnt_i  in  1  synchronous clear of conflict_cnt_o

Behaviour:
- Reset (async, rst_ni=0): all RR pointers=0, response pipeline cleared, conflict_cnt_o=0. Outputs rsp_valid_o=0 and rsp_data_o=0 during and after reset until the first grant. All mem_* outputs are combinational and 0 while no request is valid.
- Address map: bank = addr[$clog2(NumBanks)-1:0]; row = addr[AddrWidth-1:$clog2(NumBanks)].
- Arbitration, per bank, purely combinational within the cycle:
  - Candidates are ports with req_valid_i whose address selects that bank.
  - The winner is the first candidate at or after rr_ptr[bank], wrapping modulo NumPorts.
  - The winner gets req_ready_o=1 and drives mem_* for that bank.
  - Losers get req_ready_o=0 and must hold their request stable (TCDM rule: valid stays high, payload unchanged, until ready).
- RR update: on a grant in bank b, rr_ptr[b] <= (winner+1) mod NumPorts. With no grant, the pointer holds. Pointers are independent per bank.
- Zero-latency grant: req_ready_o depends combinationally on req_valid_i and addresses. There is no path from rsp to req.
- Response: a port granted at cycle t sees rsp_valid_o=1 at cycle t+1.
  - Read: rsp_data_o = mem_rdata_i of the granted bank at t+1.
  - Write: rsp_data_o = 0.
  - Responses have no backpressure; the consumer must accept them.
  - A port may issue a new request every cycle; this gives full throughput when there are no conflicts.
- Per-port registered state: rsp_valid_q, bank_sel_q, was_read_q. Data is muxed combinationally from mem_rdata_i using bank_sel_q.
- Write with strobe: mem_be_o = req_strb_i. A write with all-zero strobe is still granted and still responds.
- Conflict counter:
  - Each cycle it adds the number of ports with req_valid_i=1 and req_ready_o=0 (0..NumPorts-1).
  - It saturates at 2^CntWidth-1.
  - clear_cnt_i has priority over increment: the counter becomes 0 that cycle, and that cycle's stalls are not counted.
- Read/write to the same row in consecutive cycles: the read observes the prior write. This is bank-inherent; no forwarding logic is required.
- Reset mid-operation: an in-flight response is discarded; rsp_valid_o=0 from reset assertion.
- NumPorts=1: arbitration degenerates to pass-through; the counter stays at 0.

Test Plan:
- Single read: port0 reads addr 0x005 (bank1, row1), mem_rdata bank1 = 0xDEAD → mem_req_o=4'b0010, mem_addr_o[bank1]=1; next cycle rsp_valid_o[0]=1, rsp_data_o[0]=0xDEAD.
- Parallel no conflict: port0 addr 0x004, port1 addr 0x007, both reads → both ready same cycle, banks 0 and 3 enabled, both responses at t+1, conflict_cnt_o stays 0.
- Conflict round-robin: both ports continuously request bank2 (0x002, 0x006) for 4 cycles, re-issuing after each grant → grants alternate port0, port1, port0, port1; conflict_cnt_o=4.
- Write then read: port1 writes 0x00A data 0x1122334455667788 strb 0x0F; next cycle it reads 0x00A → mem_be_o=0x0F and mem_we_o=1 on the write; write rsp_data=0; read returns the bank model's merged value (lower 4 bytes updated).
- Counter saturation/clear: CntWidth=4, sustained 2-port conflict for 20 cycles → counter holds 15; assert clear_cnt_i with a conflict present → 0 the next cycle.
- Reset mid-flight: grant a read, assert rst_ni=0 before t+1 → rsp_valid_o=0 immediately; after release, rr_ptr=0, so a conflicting request pair grants port0 first.
